// File: rtl/dot_seq_pkg.sv
// Shared definitions for the dot_seq sequencer and its datapath wrapper:
// FSM state encoding and default widths / pipeline latency.
package dot_seq_pkg;

  localparam int unsigned W_DEF        = 32;
  localparam int unsigned LEN_W_DEF    = 16;
  localparam int unsigned PIPE_LAT_DEF = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/dot_seq_tag.sv
// Valid-tag shift register that follows beats through the PIPE_LAT-deep
// dual-MAC datapath; tag_out marks the cycle a real result sits on mul_c.
module dot_seq_tag
  import dot_seq_pkg::*;
#(
  parameter int unsigned PIPE_LAT = PIPE_LAT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic i_fire,
  output logic o_tag_out,
  output logic o_all_zero
);

  logic [PIPE_LAT-1:0] r_tag;
  logic [PIPE_LAT-1:0] w_tag_next;

  always_comb begin
    w_tag_next    = r_tag << 1;
    w_tag_next[0] = i_fire;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tag <= '0;
    end else begin
      r_tag <= w_tag_next;
    end
  end

  // all_zero looks one edge ahead: true when no beat remains in flight after
  // the current edge, which lets the final accumulate and DONE coincide.
  assign o_tag_out  = r_tag[PIPE_LAT-1];
  assign o_all_zero = (w_tag_next == '0);

endmodule

// File: rtl/dot_seq.sv
// Job sequencer for the external 2-stage dual-MAC datapath: feeds LEN beats,
// accumulates tagged results and reports the dot product.
// Optional sticky unsigned-overflow flag enabled by DOT_SEQ_OVF_EN.
module dot_seq
  import dot_seq_pkg::*;
#(
  parameter int unsigned W        = W_DEF,
  parameter int unsigned LEN_W    = LEN_W_DEF,
  parameter int unsigned PIPE_LAT = PIPE_LAT_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [W-1:0]     op_a1,
  input  logic [W-1:0]     op_b1,
  input  logic [W-1:0]     op_a2,
  input  logic [W-1:0]     op_b2,
  output logic [W-1:0]     mul_a1,
  output logic [W-1:0]     mul_b1,
  output logic [W-1:0]     mul_a2,
  output logic [W-1:0]     mul_b2,
  input  logic [W-1:0]     mul_c,
  output logic             busy,
  output logic [W-1:0]     res,
`ifdef DOT_SEQ_OVF_EN
  output logic             ovf,
`endif
  output logic             res_valid
);

  state_t           r_state;
  state_t           w_state_next;
  logic [LEN_W-1:0] r_cnt;
  logic [W-1:0]     r_acc;
  logic [W:0]       w_sum;
  logic             w_fire;
  logic             w_start_ok;
  logic             w_tag_out;
  logic             w_all_zero;

  assign op_ready   = (r_state == FEED);
  assign w_fire     = op_valid & op_ready;
  assign w_start_ok = start & ((r_state == IDLE) | (r_state == DONE));
  assign w_sum      = {1'b0, r_acc} + {1'b0, mul_c};

  // Bubbles push zero operands so the datapath never sees stale data.
  assign mul_a1 = w_fire ? op_a1 : '0;
  assign mul_b1 = w_fire ? op_b1 : '0;
  assign mul_a2 = w_fire ? op_a2 : '0;
  assign mul_b2 = w_fire ? op_b2 : '0;

  dot_seq_tag #(
    .PIPE_LAT (PIPE_LAT)
  ) u_tag (
    .clk        (clk),
    .reset      (reset),
    .i_fire     (w_fire),
    .o_tag_out  (w_tag_out),
    .o_all_zero (w_all_zero)
  );

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE, DONE: begin
        if (start) begin
          w_state_next = (len == '0) ? DONE : FEED;
        end
      end
      FEED: begin
        if (w_fire && (r_cnt == LEN_W'(1))) begin
          w_state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (w_all_zero) begin
          w_state_next = DONE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (w_start_ok) begin
      r_cnt <= len;
    end else if (w_fire) begin
      r_cnt <= r_cnt - LEN_W'(1);
    end
  end

  // Start clears the sum; tags are all zero in IDLE/DONE so no accumulate collides.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc <= '0;
    end else if (w_start_ok) begin
      r_acc <= '0;
    end else if (w_tag_out) begin
      r_acc <= w_sum[W-1:0];
    end
  end

`ifdef DOT_SEQ_OVF_EN
  logic r_ovf;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ovf <= 1'b0;
    end else if (w_start_ok) begin
      r_ovf <= 1'b0;
    end else if (w_tag_out && w_sum[W]) begin
      r_ovf <= 1'b1;
    end
  end

  assign ovf = r_ovf;
`endif

  assign busy      = (r_state == FEED) | (r_state == DRAIN);
  assign res_valid = (r_state == DONE);
  assign res       = r_acc;

endmodule

// File: tb/tb_dot_seq.sv
// Self-checking bench for dot_seq with a behavioural 2-stage dual-MAC
// datapath and an arithmetic reference model of the expected dot product.
module tb_dot_seq;

  localparam int W        = 32;
  localparam int LEN_W    = 16;
  localparam int PIPE_LAT = 2;

  typedef struct {
    logic [31:0] a1;
    logic [31:0] b1;
    logic [31:0] a2;
    logic [31:0] b2;
  } beat_t;

  logic             clk;
  logic             reset;
  logic             start;
  logic [LEN_W-1:0] len;
  logic             op_valid;
  logic             op_ready;
  logic [W-1:0]     op_a1, op_b1, op_a2, op_b2;
  logic [W-1:0]     mul_a1, mul_b1, mul_a2, mul_b2;
  logic [W-1:0]     mul_c;
  logic             busy;
  logic [W-1:0]     res;
  logic             res_valid;
`ifdef DOT_SEQ_OVF_EN
  logic             ovf;
`endif

  int checks = 0;
  int errors = 0;
  beat_t beats[$];

  dot_seq #(
    .W        (W),
    .LEN_W    (LEN_W),
    .PIPE_LAT (PIPE_LAT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .len       (len),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .op_a1     (op_a1),
    .op_b1     (op_b1),
    .op_a2     (op_a2),
    .op_b2     (op_b2),
    .mul_a1    (mul_a1),
    .mul_b1    (mul_b1),
    .mul_a2    (mul_a2),
    .mul_b2    (mul_b2),
    .mul_c     (mul_c),
    .busy      (busy),
    .res       (res),
`ifdef DOT_SEQ_OVF_EN
    .ovf       (ovf),
`endif
    .res_valid (res_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural sibling datapath: two register stages, no reset.
  logic [W-1:0] dpStage;
  always_ff @(posedge clk) begin
    dpStage <= mul_a1 * mul_b1 + mul_a2 * mul_b2;
    mul_c   <= dpStage;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Dot product of the queued beats: 32-bit products, 32-bit wrapping sum,
  // overflow whenever a running sum crosses 2^32.
  function automatic void refModel(output logic [31:0] sum, output logic ovfExp);
    longint unsigned acc;
    longint unsigned c;
    acc    = 0;
    ovfExp = 1'b0;
    foreach (beats[i]) begin
      c = (longint'(beats[i].a1) * longint'(beats[i].b1)
         + longint'(beats[i].a2) * longint'(beats[i].b2)) & 64'hFFFF_FFFF;
      acc = acc + c;
      if ((acc >> 32) != 0) ovfExp = 1'b1;
      acc = acc & 64'hFFFF_FFFF;
    end
    sum = acc[31:0];
  endfunction

  task automatic randomOps();
    op_a1 = $urandom;
    op_b1 = $urandom;
    op_a2 = $urandom;
    op_b2 = $urandom;
  endtask

  // Runs one job over the queued beats with random gaps of up to maxGap
  // cycles; pulseStart re-requests a len=5 job during the first beat.
  task automatic applyStimulus(input string name, input int maxGap, input bit pulseStart);
    logic [31:0] expSum;
    logic        expOvf;
    int          gaps;
    refModel(expSum, expOvf);
    @(negedge clk);
    start = 1'b1;
    len   = LEN_W'(beats.size());
    #1 checkOutput({name, "/busy_at_start"}, 32'(busy), 32'd0);
    @(negedge clk);
    start = 1'b0;
    if (beats.size() == 0) begin
      #1;
      checkOutput({name, "/res_valid"}, 32'(res_valid), 32'd1);
      checkOutput({name, "/res"}, res, 32'd0);
      checkOutput({name, "/busy"}, 32'(busy), 32'd0);
`ifdef DOT_SEQ_OVF_EN
      checkOutput({name, "/ovf"}, 32'(ovf), 32'd0);
`endif
      return;
    end
    foreach (beats[i]) begin
      gaps = (maxGap < 0) ? -maxGap : ((maxGap == 0) ? 0 : int'($urandom_range(maxGap, 0)));
      for (int g = 0; g < gaps; g++) begin
        op_valid = 1'b0;
        randomOps();
        #1;
        checkOutput({name, "/gap_ready"}, 32'(op_ready), 32'd1);
        checkOutput({name, "/gap_mul_zero"}, mul_a1 | mul_b1 | mul_a2 | mul_b2, 32'd0);
        @(negedge clk);
      end
      op_valid = 1'b1;
      op_a1 = beats[i].a1;
      op_b1 = beats[i].b1;
      op_a2 = beats[i].a2;
      op_b2 = beats[i].b2;
      if (pulseStart && i == 0) begin
        start = 1'b1;
        len   = LEN_W'(5);
      end
      #1;
      checkOutput({name, "/feed_ready"}, 32'(op_ready), 32'd1);
      checkOutput({name, "/feed_busy"}, 32'(busy), 32'd1);
      checkOutput({name, "/mul_a1"}, mul_a1, beats[i].a1);
      checkOutput({name, "/mul_b2"}, mul_b2, beats[i].b2);
      @(negedge clk);
      start = 1'b0;
    end
    op_valid = 1'b0;
    randomOps();
    #1;
    checkOutput({name, "/drain_ready"}, 32'(op_ready), 32'd0);
    checkOutput({name, "/drain_busy1"}, 32'(busy), 32'd1);
    checkOutput({name, "/drain_valid1"}, 32'(res_valid), 32'd0);
    checkOutput({name, "/drain_mul_zero"}, mul_a1 | mul_b1 | mul_a2 | mul_b2, 32'd0);
    @(negedge clk);
    checkOutput({name, "/drain_busy2"}, 32'(busy), 32'd1);
    checkOutput({name, "/drain_valid2"}, 32'(res_valid), 32'd0);
    @(negedge clk);
    checkOutput({name, "/done_valid"}, 32'(res_valid), 32'd1);
    checkOutput({name, "/done_busy"}, 32'(busy), 32'd0);
    checkOutput({name, "/res"}, res, expSum);
`ifdef DOT_SEQ_OVF_EN
    checkOutput({name, "/ovf"}, 32'(ovf), 32'(expOvf));
`endif
    @(negedge clk);
    checkOutput({name, "/done_hold"}, 32'(res_valid), 32'd1);
    checkOutput({name, "/res_hold"}, res, expSum);
  endtask

  task automatic pushBeat(input logic [31:0] a1, input logic [31:0] b1,
                          input logic [31:0] a2, input logic [31:0] b2);
    beat_t b;
    b.a1 = a1; b.b1 = b1; b.a2 = a2; b.b2 = b2;
    beats.push_back(b);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    len      = '0;
    op_valid = 1'b0;
    randomOps();
    repeat (3) @(negedge clk);
    checkOutput("reset/busy", 32'(busy), 32'd0);
    checkOutput("reset/op_ready", 32'(op_ready), 32'd0);
    checkOutput("reset/res_valid", 32'(res_valid), 32'd0);
    checkOutput("reset/res", res, 32'd0);
`ifdef DOT_SEQ_OVF_EN
    checkOutput("reset/ovf", 32'(ovf), 32'd0);
`endif
    reset = 1'b0;

    beats.delete();
    pushBeat(1, 2, 3, 4);
    pushBeat(5, 6, 7, 8);
    applyStimulus("basic", 0, 1'b0);

    applyStimulus("bubbles", -2, 1'b0);

    beats.delete();
    applyStimulus("len0", 0, 1'b0);

    pushBeat(32'h0001_0000, 32'h0000_8000, 0, 0);
    pushBeat(32'h0001_0000, 32'h0000_8000, 0, 0);
    applyStimulus("wrap", 0, 1'b0);

    beats.delete();
    pushBeat(1, 1, 0, 0);
    applyStimulus("after_wrap", 0, 1'b0);

    // Abort a len=3 job after one accepted beat.
    @(negedge clk);
    start = 1'b1;
    len   = LEN_W'(3);
    @(negedge clk);
    start    = 1'b0;
    op_valid = 1'b1;
    randomOps();
    @(negedge clk);
    op_valid = 1'b0;
    reset    = 1'b1;
    #1;
    checkOutput("abort/busy", 32'(busy), 32'd0);
    checkOutput("abort/op_ready", 32'(op_ready), 32'd0);
    checkOutput("abort/res_valid", 32'(res_valid), 32'd0);
    checkOutput("abort/res", res, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    beats.delete();
    pushBeat(2, 3, 0, 0);
    applyStimulus("post_abort", 0, 1'b0);

    beats.delete();
    pushBeat(32'h11, 32'h22, 32'h33, 32'h44);
    pushBeat(32'h55, 32'h66, 32'h77, 32'h88);
    applyStimulus("start_ignored", 1, 1'b1);

    for (int j = 0; j < 5; j++) begin
      int n;
      beats.delete();
      n = int'($urandom_range(6, 1));
      for (int k = 0; k < n; k++) begin
        pushBeat($urandom, $urandom, $urandom, $urandom);
      end
      applyStimulus("random", 2, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
